potential_sram: RTL

Memory-side responder for the accelerator's membrane-potential port: a 512 x 128-bit synchronous store that answers the accelerator's `u_read_sram_addr` and `u_write_sram*` requests. It also provides a host valid/ready port for initialisation and readback, and a hardware clear engine that zeroes all potentials between inferences. It sits beside the accelerator in the top-level and owns all potential storage.

---
 rtl/potential_sram_if.sv | 43 ++++
 rtl/potential_sram.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/potential_sram_if.sv
// potential_sram_if: accelerator potential port, host valid/ready port and
// clear-engine controls grouped into a single bus. The master modport is the
// requester side (accelerator + host); the slave modport is the memory side.
interface potential_sram_if #(
    parameter int AW = 9,
    parameter int DW = 128
);
    // Accelerator read/write port
    logic [AW-1:0] acc_rd_addr;
    logic [DW-1:0] acc_rd_data;
    logic [AW-1:0] acc_wr_addr;
    logic [DW-1:0] acc_wr_data;
    logic          acc_wr_en;
    logic          acc_busy;
    // Host valid/ready port
    logic          host_req_valid;
    logic          host_req_ready;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_rsp_valid;
    logic [DW-1:0] host_rsp_data;
    // Clear engine and status
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic          acc_conflict;
    logic          parity_err;

    modport master (
        output acc_rd_addr, acc_wr_addr, acc_wr_data, acc_wr_en, acc_busy,
        output host_req_valid, host_we, host_addr, host_wdata, clear_start,
        input  acc_rd_data, host_req_ready, host_rsp_valid, host_rsp_data,
        input  clear_busy, clear_done, acc_conflict, parity_err
    );

    modport slave (
        input  acc_rd_addr, acc_wr_addr, acc_wr_data, acc_wr_en, acc_busy,
        input  host_req_valid, host_we, host_addr, host_wdata, clear_start,
        output acc_rd_data, host_req_ready, host_rsp_valid, host_rsp_data,
        output clear_busy, clear_done, acc_conflict, parity_err
    );
endinterface

// File: rtl/potential_sram.sv
// potential_sram: 512 x 128-bit membrane-potential store. Serves one
// accelerator read and one accelerator write per cycle, a host valid/ready
// port when the accelerator is idle, and a zeroing sweep engine.
// Optional macro POTENTIAL_SRAM_PARITY_EN adds one parity bit per word and a
// registered parity_err aligned with acc_rd_data.
module potential_sram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 128
) (
    input  logic             clk,
    input  logic             reset,
    potential_sram_if.slave  bus
);
`ifdef POTENTIAL_SRAM_PARITY_EN
    localparam int MW = DW + 1;   // parity bit stored above the data
`else
    localparam int MW = DW;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          clear_done_q;
    logic          acc_conflict_q;
    logic [DW-1:0] acc_rd_data_q;
    logic          parity_err_q;
    logic          host_rsp_valid_q;
    logic [DW-1:0] host_rsp_data_q;

    // Storage is never reset so it can map onto block RAM.
    logic [MW-1:0] mem_q [DEPTH];

    logic          in_clear;
    logic          host_ready;
    logic          host_accept;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] acc_rd_word;
    logic          rd_perr;

    assign in_clear    = (state_q == CLEAR);
    assign host_ready  = (state_q == IDLE) && !bus.acc_busy && !bus.acc_wr_en;
    assign host_accept = bus.host_req_valid && host_ready;
    assign acc_rd_word = mem_q[bus.acc_rd_addr];

`ifdef POTENTIAL_SRAM_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
    // XOR over data plus stored parity is 1 exactly when they disagree.
    assign rd_perr = ^acc_rd_word;
`else
    assign wr_word = wr_data;
    assign rd_perr = 1'b0;
`endif

    // Single write port: the sweep, accelerator and host never need to write
    // in the same cycle, because host access is gated off by acc_wr_en and by
    // the sweep, and accelerator writes are dropped while sweeping.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (in_clear) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
        end else if (bus.acc_wr_en) begin
            wr_en   = 1'b1;
            wr_addr = bus.acc_wr_addr;
            wr_data = bus.acc_wr_data;
        end else if (host_accept && bus.host_we) begin
            wr_en   = 1'b1;
            wr_addr = bus.host_addr;
            wr_data = bus.host_wdata;
        end
    end

    // Array write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    // Clear sweep FSM with its done pulse and the sticky conflict flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            clear_done_q   <= 1'b0;
            acc_conflict_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    clear_done_q <= 1'b0;
                    if (bus.clear_start) begin
                        state_q        <= CLEAR;
                        cnt_q          <= '0;
                        acc_conflict_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (bus.acc_wr_en) begin
                        acc_conflict_q <= 1'b1;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    // Done is visible during the cycle whose edge writes the
                    // last word, i.e. the final busy cycle.
                    clear_done_q <= (cnt_q == AW'(DEPTH - 2));
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Accelerator read: write-first bypass, zero while sweeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_rd_data_q <= '0;
            parity_err_q  <= 1'b0;
        end else if (in_clear) begin
            acc_rd_data_q <= '0;
            parity_err_q  <= 1'b0;
        end else if (bus.acc_wr_en && (bus.acc_wr_addr == bus.acc_rd_addr)) begin
            acc_rd_data_q <= bus.acc_wr_data;
            parity_err_q  <= 1'b0;
        end else begin
            acc_rd_data_q <= acc_rd_word[DW-1:0];
            parity_err_q  <= rd_perr;
        end
    end

    // Host read response: one-cycle pulse, data held until the next read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rsp_valid_q <= 1'b0;
            host_rsp_data_q  <= '0;
        end else begin
            host_rsp_valid_q <= host_accept && !bus.host_we;
            if (host_accept && !bus.host_we) begin
                host_rsp_data_q <= mem_q[bus.host_addr][DW-1:0];
            end
        end
    end

    assign bus.acc_rd_data    = acc_rd_data_q;
    assign bus.parity_err     = parity_err_q;
    assign bus.host_req_ready = host_ready;
    assign bus.host_rsp_valid = host_rsp_valid_q;
    assign bus.host_rsp_data  = host_rsp_data_q;
    assign bus.clear_busy     = in_clear;
    assign bus.clear_done     = clear_done_q;
    assign bus.acc_conflict   = acc_conflict_q;
endmodule
